banco_reg_sync: RTL and testbench

Clocked, parametrised successor to the combinational register bank; it serves as the datapath register file for the pipelined core.
- One write port and two read ports; read data is registered, one-cycle latency, with a per-port valid strobe.
- Self-clearing: after reset, a state machine sweeps every entry to zero, raising Busy until the sweep completes.
- Optional register zero hardwiring, plus compile-time write-to-read bypass.

---
 rtl/banco_reg_sync.sv | 151 +++++++++++++++
 tb/tb_banco_reg_sync.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/banco_reg_sync.sv
// banco_reg_sync: synchronous datapath register file with one write port and
// two registered read ports. After reset a clear sweep zeroes every entry
// while Busy is high. Entry 0 can be hardwired to zero (ZERO_REG).
// Optional compile-time macro BREG_BYPASS_EN forwards same-edge write data
// to a read of the same address.

// Registered read stage: captures the selected read data and raises valid for
// one cycle per accepted read; data holds when no read is accepted.
module breg_rd_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              re,
  input  logic [DATA_W-1:0] rd,
  output logic [DATA_W-1:0] dr,
  output logic              valid
);

  // Output register: clears on reset, loads only on an accepted read.
  always_ff @(posedge clk) begin
    if (rst) begin
      dr    <= '0;
      valid <= 1'b0;
    end else begin
      valid <= rdy & re;
      if (rdy & re) dr <= rd;
    end
  end

endmodule

module banco_reg_sync #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] AW,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              RE1,
  input  logic [ADDR_W-1:0] RA1,
  input  logic              RE2,
  input  logic [ADDR_W-1:0] RA2,
  output logic [DATA_W-1:0] DR1,
  output logic [DATA_W-1:0] DR2,
  output logic              Valid1,
  output logic              Valid2,
  output logic              Busy
);

  localparam int DEPTH     = 2**ADDR_W;
  localparam int NUM_PORTS = 2;

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic              clr_we;
  logic              wr_ok;
  logic              rdy;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [NUM_PORTS-1:0][ADDR_W-1:0] ra_v;
  logic [NUM_PORTS-1:0]             re_v;
  logic [NUM_PORTS-1:0]             byp_hit;
  logic [NUM_PORTS-1:0][DATA_W-1:0] rd_sel;
  logic [NUM_PORTS-1:0][DATA_W-1:0] dr_v;
  logic [NUM_PORTS-1:0]             vld_v;

  assign rdy  = (state == READY);
  assign Busy = (state == CLEAR);

  // Writes to entry 0 are dropped when it is hardwired; only legal in READY.
  assign wr_ok = rdy & RegWrite & ~((ZERO_REG != 0) && (AW == '0));

  // State and sweep counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: CLEAR walks every entry once, then hands over to READY.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clr_we    = 1'b0;
    case (state)
      CLEAR: begin
        clr_we  = 1'b1;
        cnt_nxt = cnt + 1'b1;
        if (cnt == {ADDR_W{1'b1}}) begin
          state_nxt = READY;
          cnt_nxt   = '0;
        end
      end
      READY: ;
      default: state_nxt = CLEAR;
    endcase
  end

  // Storage array: sweep clear or port write; the two never coincide.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we)     mem[cnt] <= '0;
      else if (wr_ok) mem[AW]  <= WriteData;
    end
  end

  assign ra_v = {RA2, RA1};
  assign re_v = {RE2, RE1};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd
`ifdef BREG_BYPASS_EN
    assign byp_hit[p] = wr_ok & (AW == ra_v[p]);
`else
    assign byp_hit[p] = 1'b0;
`endif

    // Read mux: hardwired zero wins, then forwarded write data, then array.
    always_comb begin
      rd_sel[p] = mem[ra_v[p]];
      if (byp_hit[p]) rd_sel[p] = WriteData;
      if ((ZERO_REG != 0) && (ra_v[p] == '0)) rd_sel[p] = '0;
    end

    breg_rd_stage #(.DATA_W(DATA_W)) u_rd (
      .clk   (clk),
      .rst   (rst),
      .rdy   (rdy),
      .re    (re_v[p]),
      .rd    (rd_sel[p]),
      .dr    (dr_v[p]),
      .valid (vld_v[p])
    );
  end

  assign DR1    = dr_v[0];
  assign DR2    = dr_v[1];
  assign Valid1 = vld_v[0];
  assign Valid2 = vld_v[1];

endmodule

// File: tb/tb_banco_reg_sync.sv
// Directed bench for banco_reg_sync: a ZERO_REG=1 instance and a ZERO_REG=0
// instance share stimulus; table vectors cover READY behaviour, hand-written
// sequences cover the clear sweep and mid-operation reset.
module tb_banco_reg_sync;

`ifdef BREG_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWrite;
  logic [4:0]  AW;
  logic [31:0] WriteData;
  logic        RE1, RE2;
  logic [4:0]  RA1, RA2;
  logic [31:0] DR1, DR2, dr1b, dr2b;
  logic        Valid1, Valid2, Busy, v1b, v2b, busyb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  banco_reg_sync #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .RegWrite(RegWrite), .AW(AW), .WriteData(WriteData),
    .RE1(RE1), .RA1(RA1), .RE2(RE2), .RA2(RA2),
    .DR1(DR1), .DR2(DR2), .Valid1(Valid1), .Valid2(Valid2), .Busy(Busy)
  );

  banco_reg_sync #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) dut0 (
    .clk(clk), .rst(rst), .RegWrite(RegWrite), .AW(AW), .WriteData(WriteData),
    .RE1(RE1), .RA1(RA1), .RE2(RE2), .RA2(RA2),
    .DR1(dr1b), .DR2(dr2b), .Valid1(v1b), .Valid2(v2b), .Busy(busyb)
  );

  typedef struct {
    logic        rw;
    logic [4:0]  aw;
    logic [31:0] wd;
    logic        re1;
    logic [4:0]  ra1;
    logic        re2;
    logic [4:0]  ra2;
    logic [31:0] dr1;
    logic        v1;
    logic [31:0] dr2;
    logic        v2;
    logic [31:0] dr1b;
  } vec_t;

  vec_t vt[15];

  function automatic vec_t mk(logic rw, logic [4:0] aw, logic [31:0] wd,
                              logic re1, logic [4:0] ra1, logic re2, logic [4:0] ra2,
                              logic [31:0] dr1, logic v1, logic [31:0] dr2, logic v2,
                              logic [31:0] dr1b);
    vec_t v;
    v.rw = rw; v.aw = aw; v.wd = wd; v.re1 = re1; v.ra1 = ra1; v.re2 = re2; v.ra2 = ra2;
    v.dr1 = dr1; v.v1 = v1; v.dr2 = dr2; v.v2 = v2; v.dr1b = dr1b;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RegWrite = 1'b0; AW = '0; WriteData = '0;
    RE1 = 1'b0; RA1 = '0; RE2 = 1'b0; RA2 = '0;
  endtask

  // Counts edges until Busy drops (bounded); flags any valid during the sweep.
  task automatic wait_sweep(input string name);
    int   n = 0;
    logic sawv = 1'b0;
    while (n < 64) begin
      step();
      n++;
      if (Valid1 || Valid2 || DR1 != 0 || DR2 != 0) sawv = 1'b1;
      if (!Busy) break;
    end
    chk({name, "_len"}, n, 32);
    chk({name, "_quiet"}, {31'b0, sawv}, 32'd0);
  endtask

  initial begin
    vt[0]  = mk(0, 0, 0,             1, 3, 0, 0, 32'h0,        1, 32'h0,        0, 32'h0);
    vt[1]  = mk(1, 7, 32'h12345678,  0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0);
    vt[2]  = mk(0, 0, 0,             1, 7, 1, 7, 32'h12345678, 1, 32'h12345678, 1, 32'h12345678);
    vt[3]  = mk(1, 0, 32'hFFFFFFFF,  0, 0, 0, 0, 32'h12345678, 0, 32'h12345678, 0, 32'h12345678);
    vt[4]  = mk(0, 0, 0,             1, 0, 0, 0, 32'h0,        1, 32'h12345678, 0, 32'hFFFFFFFF);
    vt[5]  = mk(1, 5, 32'hAAAA,      0, 0, 0, 0, 32'h0,        0, 32'h12345678, 0, 32'hFFFFFFFF);
    vt[6]  = mk(1, 5, 32'h5555,      1, 5, 0, 0, BYP ? 32'h5555 : 32'hAAAA, 1, 32'h12345678, 0,
                BYP ? 32'h5555 : 32'hAAAA);
    vt[7]  = mk(0, 0, 0,             1, 5, 0, 0, 32'h5555,     1, 32'h12345678, 0, 32'h5555);
    vt[8]  = mk(0, 0, 0,             0, 0, 1, 7, 32'h5555,     0, 32'h12345678, 1, 32'h5555);
    vt[9]  = mk(0, 0, 0,             0, 0, 0, 0, 32'h5555,     0, 32'h12345678, 0, 32'h5555);
    vt[10] = mk(0, 0, 0,             0, 0, 0, 0, 32'h5555,     0, 32'h12345678, 0, 32'h5555);
    vt[11] = mk(0, 0, 0,             0, 0, 0, 0, 32'h5555,     0, 32'h12345678, 0, 32'h5555);
    vt[12] = mk(1, 9, 32'h77,        1, 9, 1, 9, BYP ? 32'h77 : 32'h0, 1, BYP ? 32'h77 : 32'h0, 1,
                BYP ? 32'h77 : 32'h0);
    vt[13] = mk(1, 0, 32'h1234,      1, 0, 1, 0, 32'h0,        1, 32'h0,        1,
                BYP ? 32'h1234 : 32'hFFFFFFFF);
    vt[14] = mk(0, 0, 0,             1, 9, 1, 0, 32'h77,       1, 32'h0,        1, 32'h77);

    // Reset state.
    rst = 1'b1;
    idle();
    step();
    chk("rst_busy", {31'b0, Busy}, 32'd1);
    chk("rst_dr1", DR1, 32'h0);
    chk("rst_dr2", DR2, 32'h0);
    chk("rst_valid", {30'b0, Valid2, Valid1}, 32'd0);

    // First sweep with a write and a read held on the inputs; both ignored.
    rst = 1'b0;
    RegWrite = 1'b1; AW = 5'd3; WriteData = 32'hDEADBEEF;
    RE1 = 1'b1; RA1 = 5'd3; RE2 = 1'b1; RA2 = 5'd3;
    wait_sweep("sweep1");

    for (int i = 0; i < 15; i++) begin
      RegWrite = vt[i].rw; AW = vt[i].aw; WriteData = vt[i].wd;
      RE1 = vt[i].re1; RA1 = vt[i].ra1; RE2 = vt[i].re2; RA2 = vt[i].ra2;
      step();
      chk($sformatf("v%0d_dr1", i), DR1, vt[i].dr1);
      chk($sformatf("v%0d_v1", i), {31'b0, Valid1}, {31'b0, vt[i].v1});
      chk($sformatf("v%0d_dr2", i), DR2, vt[i].dr2);
      chk($sformatf("v%0d_v2", i), {31'b0, Valid2}, {31'b0, vt[i].v2});
      chk($sformatf("v%0d_dr1_z0", i), dr1b, vt[i].dr1b);
    end

    // Second reset held two edges, then interrupted on its 10th sweep edge.
    idle();
    rst = 1'b1;
    step();
    chk("rst2_dr1", DR1, 32'h0);
    chk("rst2_valid", {30'b0, Valid2, Valid1}, 32'd0);
    step();
    rst = 1'b0;
    RE1 = 1'b1; RA1 = 5'd9;
    repeat (9) step();
    chk("mid_busy", {31'b0, Busy}, 32'd1);
    rst = 1'b1;
    step();
    chk("mid_rst_busy", {31'b0, Busy}, 32'd1);
    chk("mid_rst_dr1", DR1, 32'h0);
    rst = 1'b0;
    wait_sweep("sweep2");

    idle();
    RE1 = 1'b1; RA1 = 5'd9; RE2 = 1'b1; RA2 = 5'd9;
    step();
    chk("post_dr1", DR1, 32'h0);
    chk("post_v1", {31'b0, Valid1}, 32'd1);
    chk("post_dr2", DR2, 32'h0);
    chk("post_dr1_z0", dr1b, 32'h0);
    idle();
    step();
    chk("post_idle_v", {30'b0, Valid2, Valid1}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
